tlb_plru_update: RTL and testbench



---
 rtl/tlb_plru_pkg.sv | 21 ++
 rtl/tlb_plru_update_touch_unit.sv | 18 +
 rtl/tlb_plru_update.sv | 95 +++++++++
 tb/tb_tlb_plru_update.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_plru_pkg.sv
// Shared TLB replacement-state definitions and the tree-PLRU touch helper used by both the
// writer and the victim selector.
package tlb_plru_pkg;

   localparam int unsigned TLB_ENTRIES = 8;
   localparam int unsigned TLB_IDX_W   = 3;
   localparam int unsigned PLRU_W      = 8;

   // Point every node on the path to idx away from it; bit 0 stays unused.
   function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0]    plru,
                                                     input logic [TLB_IDX_W-1:0] idx);
      logic [PLRU_W-1:0] nxt;
      nxt                        = plru;
      nxt[3'd1]                  = ~idx[2];
      nxt[{1'b0, 1'b1, idx[2]}]  = ~idx[1];
      nxt[{1'b1, idx[2:1]}]      = ~idx[0];
      nxt[0]                     = 1'b0;
      return nxt;
   endfunction

endpackage

// File: rtl/tlb_plru_update_touch_unit.sv
// Combinational tree-PLRU touch: when enabled, returns the input vector with entry idx touched.
module plru_touch_unit
   import tlb_plru_pkg::*;
(
   input  logic [PLRU_W-1:0]    plru_cur,
   input  logic                 touch_en,
   input  logic [TLB_IDX_W-1:0] touch_idx,
   output logic [PLRU_W-1:0]    plru_next
);

   always_comb begin
      plru_next = plru_cur;
      if (touch_en) begin
         plru_next = plru_touch(plru_cur, touch_idx);
      end
   end

endmodule

// File: rtl/tlb_plru_update.sv
// Writer side of the per-set TLB replacement state: registers hit/refill/invalidate requests
// for one cycle, then applies them to the PLRU tree and valid vector in a fixed order.
module tlb_plru_update
   import tlb_plru_pkg::*;
#(
   parameter int unsigned ENTRIES = TLB_ENTRIES
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 hit_valid,
   input  logic [TLB_IDX_W-1:0] hit_entry,
   input  logic                 refill_valid,
   input  logic [TLB_IDX_W-1:0] refill_entry,
   input  logic                 inval_valid,
   input  logic                 inval_all,
   input  logic [TLB_IDX_W-1:0] inval_entry,
   output logic [ENTRIES-1:0]   plru,
   output logic [ENTRIES-1:0]   valid,
   output logic                 pending
);

   logic                 hit_q;
   logic [TLB_IDX_W-1:0] hit_entry_q;
   logic                 refill_q;
   logic [TLB_IDX_W-1:0] refill_entry_q;
   logic                 inval_q;
   logic                 inval_all_q;
   logic [TLB_IDX_W-1:0] inval_entry_q;

   logic [ENTRIES-1:0]   plru_q, plru_d;
   logic [ENTRIES-1:0]   valid_q, valid_d;
   logic [PLRU_W-1:0]    plru_after_hit;
   logic [PLRU_W-1:0]    plru_after_refill;

   // Refill touches after the hit so the refilled entry is the most recent use.
   plru_touch_unit u_touch_hit (
      .plru_cur  (plru_q),
      .touch_en  (hit_q),
      .touch_idx (hit_entry_q),
      .plru_next (plru_after_hit)
   );

   plru_touch_unit u_touch_refill (
      .plru_cur  (plru_after_hit),
      .touch_en  (refill_q),
      .touch_idx (refill_entry_q),
      .plru_next (plru_after_refill)
   );

   always_comb begin
      plru_d  = plru_after_refill;
      valid_d = valid_q;
      if (refill_q) begin
         valid_d[refill_entry_q] = 1'b1;
      end
      if (inval_q) begin
         if (inval_all_q) begin
            plru_d  = '0;
            valid_d = '0;
         end else begin
            valid_d[inval_entry_q] = 1'b0;
         end
      end
      plru_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_q          <= 1'b0;
         hit_entry_q    <= '0;
         refill_q       <= 1'b0;
         refill_entry_q <= '0;
         inval_q        <= 1'b0;
         inval_all_q    <= 1'b0;
         inval_entry_q  <= '0;
         plru_q         <= '0;
         valid_q        <= '0;
      end else begin
         hit_q          <= hit_valid;
         hit_entry_q    <= hit_entry;
         refill_q       <= refill_valid;
         refill_entry_q <= refill_entry;
         inval_q        <= inval_valid;
         inval_all_q    <= inval_all;
         inval_entry_q  <= inval_entry;
         plru_q         <= plru_d;
         valid_q        <= valid_d;
      end
   end

   assign plru    = plru_q;
   assign valid   = valid_q;
   assign pending = hit_q | refill_q | inval_q;

endmodule

// File: tb/tb_tlb_plru_update.sv
// Randomised and directed bench for tlb_plru_update against a node-array replacement model.
module tb_tlb_plru_update;

   logic       clk;
   logic       rst_n;
   logic       hit_valid;
   logic [2:0] hit_entry;
   logic       refill_valid;
   logic [2:0] refill_entry;
   logic       inval_valid;
   logic       inval_all;
   logic [2:0] inval_entry;
   logic [7:0] plru;
   logic [7:0] valid;
   logic       pending;

   int total;
   int bad;

   typedef struct {
      bit hit;
      int hit_e;
      bit refill;
      int refill_e;
      bit inval;
      bit all;
      int inval_e;
   } req_t;

   // Model: tree nodes 1..7 as separate bits, entries as a bit array, one request slot.
   bit   m_node[8];
   bit   m_valid[8];
   req_t m_req;

   tlb_plru_update #(.ENTRIES(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .hit_valid    (hit_valid),
      .hit_entry    (hit_entry),
      .refill_valid (refill_valid),
      .refill_entry (refill_entry),
      .inval_valid  (inval_valid),
      .inval_all    (inval_all),
      .inval_entry  (inval_entry),
      .plru         (plru),
      .valid        (valid),
      .pending      (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic m_touch(input int e);
      for (int lvl = 0; lvl < 3; lvl++) begin
         m_node[(1 << lvl) + (e >> (3 - lvl))] = !((e >> (2 - lvl)) & 1);
      end
   endtask

   task automatic m_apply(input req_t r);
      if (r.hit) m_touch(r.hit_e);
      if (r.refill) begin
         m_touch(r.refill_e);
         m_valid[r.refill_e] = 1'b1;
      end
      if (r.inval) begin
         if (r.all) begin
            for (int i = 0; i < 8; i++) begin
               m_node[i]  = 1'b0;
               m_valid[i] = 1'b0;
            end
         end else begin
            m_valid[r.inval_e] = 1'b0;
         end
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 8; i++) begin
         m_node[i]  = 1'b0;
         m_valid[i] = 1'b0;
      end
      m_req = '{default: 0};
   endtask

   function automatic logic [7:0] m_plru_vec();
      logic [7:0] v;
      v = '0;
      for (int i = 1; i < 8; i++) v[i] = m_node[i];
      return v;
   endfunction

   function automatic logic [7:0] m_valid_vec();
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = m_valid[i];
      return v;
   endfunction

   function automatic bit m_pending();
      return m_req.hit || m_req.refill || m_req.inval;
   endfunction

   function automatic int victim_of(input logic [7:0] p);
      int idx;
      idx = 1;
      repeat (3) idx = idx * 2 + int'(p[idx]);
      return idx & 7;
   endfunction

   task automatic clear_inputs();
      hit_valid    = 1'b0;
      hit_entry    = '0;
      refill_valid = 1'b0;
      refill_entry = '0;
      inval_valid  = 1'b0;
      inval_all    = 1'b0;
      inval_entry  = '0;
   endtask

   // One rising edge: the model applies the previous slot and samples the current inputs.
   task automatic tick();
      req_t cur;
      cur.hit      = hit_valid;
      cur.hit_e    = int'(hit_entry);
      cur.refill   = refill_valid;
      cur.refill_e = int'(refill_entry);
      cur.inval    = inval_valid;
      cur.all      = inval_all;
      cur.inval_e  = int'(inval_entry);
      @(posedge clk);
      m_apply(m_req);
      m_req = cur;
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      m_reset();
      #12;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      tick();
      total++;
      if (plru !== 8'h00) begin
         bad++; $display("FAIL reset_plru got=%h want=%h", plru, 8'h00);
      end
      total++;
      if (valid !== 8'h00) begin
         bad++; $display("FAIL reset_valid got=%h want=%h", valid, 8'h00);
      end
      total++;
      if (pending !== 1'b0) begin
         bad++; $display("FAIL reset_pending got=%b want=0", pending);
      end
      total++;
      if (victim_of(plru) != 0) begin
         bad++; $display("FAIL reset_victim got=%0d want=0", victim_of(plru));
      end
   endtask

   task automatic test_hit_latency();
      hit_valid = 1'b1;
      hit_entry = 3'd0;
      tick();
      clear_inputs();
      total++;
      if (pending !== 1'b1) begin
         bad++; $display("FAIL hit_pending got=%b want=1", pending);
      end
      total++;
      if (plru !== 8'h00) begin
         bad++; $display("FAIL hit_early_plru got=%h want=%h", plru, 8'h00);
      end
      tick();
      total++;
      if (plru !== 8'h16) begin
         bad++; $display("FAIL hit_plru got=%h want=%h", plru, 8'h16);
      end
      total++;
      if (valid !== 8'h00) begin
         bad++; $display("FAIL hit_valid got=%h want=%h", valid, 8'h00);
      end
      total++;
      if (victim_of(plru) != 4) begin
         bad++; $display("FAIL hit_victim got=%0d want=4", victim_of(plru));
      end
      total++;
      if (pending !== 1'b0) begin
         bad++; $display("FAIL hit_pending_clr got=%b want=0", pending);
      end
   endtask

   task automatic test_hit_refill();
      do_reset();
      hit_valid    = 1'b1;
      hit_entry    = 3'd0;
      refill_valid = 1'b1;
      refill_entry = 3'd3;
      tick();
      clear_inputs();
      tick();
      total++;
      if (plru !== 8'h12) begin
         bad++; $display("FAIL hitrefill_plru got=%h want=%h", plru, 8'h12);
      end
      total++;
      if (valid !== 8'h08) begin
         bad++; $display("FAIL hitrefill_valid got=%h want=%h", valid, 8'h08);
      end
   endtask

   task automatic test_back_to_back(input bit check_each);
      for (int e = 0; e < 8; e++) begin
         refill_valid = 1'b1;
         refill_entry = 3'(e);
         tick();
         if (check_each) begin
            total++;
            if (valid !== m_valid_vec() || plru !== m_plru_vec()) begin
               bad++;
               $display("FAIL b2b_step%0d got=%h/%h want=%h/%h", e, valid, plru,
                        m_valid_vec(), m_plru_vec());
            end
         end
      end
      clear_inputs();
      if (check_each) begin
         total++;
         if (valid !== 8'h7F) begin
            bad++; $display("FAIL b2b_last_minus1 got=%h want=%h", valid, 8'h7F);
         end
      end
      tick();
      total++;
      if (valid !== 8'hFF) begin
         bad++; $display("FAIL b2b_full got=%h want=%h", valid, 8'hFF);
      end
      total++;
      if (plru !== m_plru_vec()) begin
         bad++; $display("FAIL b2b_plru got=%h want=%h", plru, m_plru_vec());
      end
   endtask

   task automatic test_inval_all();
      refill_valid = 1'b1;
      refill_entry = 3'd2;
      inval_valid  = 1'b1;
      inval_all    = 1'b1;
      tick();
      clear_inputs();
      tick();
      total++;
      if (valid !== 8'h00) begin
         bad++; $display("FAIL invall_valid got=%h want=%h", valid, 8'h00);
      end
      total++;
      if (plru !== 8'h00) begin
         bad++; $display("FAIL invall_plru got=%h want=%h", plru, 8'h00);
      end
   endtask

   task automatic test_single_inval();
      logic [7:0] pre;
      test_back_to_back(1'b0);
      pre          = m_plru_vec();
      hit_valid    = 1'b1;
      hit_entry    = 3'd5;
      inval_valid  = 1'b1;
      inval_entry  = 3'd5;
      tick();
      clear_inputs();
      tick();
      total++;
      if (valid !== 8'hDF) begin
         bad++; $display("FAIL inv1_valid got=%h want=%h", valid, 8'hDF);
      end
      total++;
      if (plru !== m_plru_vec() || plru[1] !== 1'b0 || plru[3] !== 1'b1 || plru[6] !== 1'b0) begin
         bad++; $display("FAIL inv1_plru got=%h want=%h (pre %h)", plru, m_plru_vec(), pre);
      end
      // Reset while a request sits in the request register.
      hit_valid = 1'b1;
      hit_entry = 3'd7;
      tick();
      total++;
      if (pending !== 1'b1) begin
         bad++; $display("FAIL midrst_pre_pending got=%b want=1", pending);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (plru !== 8'h00 || valid !== 8'h00 || pending !== 1'b0) begin
         bad++; $display("FAIL midrst_async got=%h/%h/%b want=00/00/0", plru, valid, pending);
      end
      clear_inputs();
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      total++;
      if (plru !== 8'h00 || valid !== 8'h00 || pending !== 1'b0) begin
         bad++; $display("FAIL midrst_lost got=%h/%h/%b want=00/00/0", plru, valid, pending);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         hit_valid    = ($urandom_range(0, 1) == 1);
         hit_entry    = 3'($urandom_range(0, 7));
         refill_valid = ($urandom_range(0, 2) == 0);
         refill_entry = 3'($urandom_range(0, 7));
         inval_valid  = ($urandom_range(0, 5) == 0);
         inval_all    = ($urandom_range(0, 3) == 0);
         inval_entry  = 3'($urandom_range(0, 7));
         tick();
         total++;
         if (plru !== m_plru_vec() || valid !== m_valid_vec() || pending !== m_pending()) begin
            bad++;
            $display("FAIL rand_cyc%0d got=%h/%h/%b want=%h/%h/%b", n, plru, valid, pending,
                     m_plru_vec(), m_valid_vec(), m_pending());
         end
      end
      clear_inputs();
      tick();
      tick();
      total++;
      if (plru !== m_plru_vec() || valid !== m_valid_vec() || pending !== 1'b0) begin
         bad++;
         $display("FAIL rand_drain got=%h/%h/%b want=%h/%h/0", plru, valid, pending,
                  m_plru_vec(), m_valid_vec());
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      clear_inputs();
      rst_n = 1'b0;
      test_reset();
      test_hit_latency();
      test_hit_refill();
      do_reset();
      test_back_to_back(1'b1);
      test_inval_all();
      test_single_inval();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
